dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arb_starve.sv | 28 ++
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read owner tag, counter width.
package dmem_arb_pkg;

  typedef enum logic {
    ARB     = 1'b0,
    LOCK_M1 = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/dmem_arb_starve.sv
// Saturating count of consecutive cycles the loader port asked for memory and was refused.
module dmem_arb_starve
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic m1_req,
  input  logic m1_gnt,
  output logic starve_full
);

  localparam logic [STARVE_CNT_W-1:0] MAX_C = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || !m1_req || m1_gnt) begin
      cnt_q <= '0;
    end else if (cnt_q != MAX_C) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign starve_full = (cnt_q == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a synchronous data memory: core (m0) over loader (m1),
// with an m1 ownership lock. Starvation guard for m1 built only with DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must lie in 1..15");
  end

  arb_state_t state_q, state_d;
  logic       starve_full;
  logic       m0_win, m1_win;
  logic       vld_p1;
  owner_t     owner_p1;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  dmem_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk         (clk),
    .rst         (rst),
    .m1_req      (m1_req),
    .m1_gnt      (m1_win),
    .starve_full (starve_full)
  );
`else
  assign starve_full = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (m1_win && m1_lock) state_d = LOCK_M1;
      LOCK_M1: if (!m1_lock)          state_d = ARB;
      default:                        state_d = ARB;
    endcase
  end

  // Force only when m1 still asks, so a withdrawn request never steals a cycle from m0.
  always_comb begin
    m0_win = 1'b0;
    m1_win = 1'b0;
    if (!rst) begin
      case (state_q)
        ARB: begin
          if (starve_full && m1_req) m1_win = 1'b1;
          else if (m0_req)           m0_win = 1'b1;
          else if (m1_req)           m1_win = 1'b1;
        end
        LOCK_M1: m1_win = m1_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    m0_gnt   = m0_win;
    m1_gnt   = m1_win;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (m1_win) begin
      mem_we   = m1_we;
      mem_addr = m1_addr;
      mem_wd   = m1_wdata;
    end else if (m0_win) begin
      mem_we   = m0_we;
      mem_addr = m0_addr;
      mem_wd   = m0_wdata;
    end
  end

  // p0 -> p1: a granted read is tagged with its owner and answered from mem_rd next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      owner_p1 <= OWN_M0;
    end else begin
      vld_p1   <= (m0_win && !m0_we) || (m1_win && !m1_we);
      owner_p1 <= m1_win ? OWN_M1 : OWN_M0;
    end
  end

  always_comb begin
    m0_rvalid = !rst && vld_p1 && (owner_p1 == OWN_M0);
    m1_rvalid = !rst && vld_p1 && (owner_p1 == OWN_M1);
    m0_rdata  = m0_rvalid ? mem_rd : '0;
    m1_rdata  = m1_rvalid ? mem_rd : '0;
  end

endmodule
